// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb_pkg
//  Description : Shared definitions for the two-requester multiplier arbiter:
//                FSM state encoding, default abort threshold and a small
//                index-to-one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rr_arbiter
//  Description : Two-way round-robin selector. A lone request wins outright;
//                when both requesters ask, the pointer picks. On every grant
//                the pointer moves to the requester that lost.
//  Ports       : clk        - clock
//                rst        - asynchronous active-low reset
//                req_i      - request vector
//                advance_i  - a grant is being issued this cycle
//                winner_o   - selected requester index
//                valid_o    - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module mult_rr_arbiter
  import mult_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       winner_o,
  output logic       valid_o
);

  logic rr_q;

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = rr_q;
      default: winner_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else if (advance_i) begin
      rr_q <= ~winner_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter_taint.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_arbiter_taint
//  Description : Shares one external multiplier between two requesters and
//                propagates a one-bit taint alongside every datapath value.
//                Flow: IDLE -> LAUNCH (grant + start) -> WAIT (product or
//                abort after TIMEOUT cycles) -> DELIVER (done pulse).
//  Ports       : clk, rst (async active-low)
//                req/req_t, mcand_in/mcand_t, mplier_in/mplier_t - requesters
//                grant, done/done_t, result/result_t, timeout_err - replies
//                mul_* - interface to the shared multiplier
//  Revision    : 1.0  initial release
// ============================================================================
module mult_share_arbiter_taint
  import mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0]           req_t,
  input  logic [2*WIDTH-1:0]   mcand_in,
  input  logic [2*WIDTH-1:0]   mplier_in,
  input  logic [1:0]           mcand_t,
  input  logic [1:0]           mplier_t,
  output logic [1:0]           grant,
  output logic [1:0]           done,
  output logic                 done_t,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_t,
  output logic                 timeout_err,
  output logic                 mul_start,
  output logic                 mul_start_t,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic                 mul_multiplier_t,
  output logic                 mul_multiplicand_t,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_product_t,
  input  logic                 mul_done,
  input  logic                 mul_done_t
);

  localparam int unsigned          c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(TIMEOUT);

  arb_state_e             state_q;
  logic                   win_q;
  logic                   dt_q;
  logic [c_cnt_w-1:0]     cnt_q;
  logic [WIDTH-1:0]       mcand_q, mplier_q;
  logic                   mcand_t_q, mplier_t_q;
  logic [1:0]             grant_q, done_q;
  logic                   done_t_q, start_q, start_t_q;
  logic [2*WIDTH-1:0]     result_q;
  logic                   result_t_q, terr_q;

  logic                   w_win, w_valid, w_launch;
  logic [WIDTH-1:0]       w_mcand, w_mplier;

  // Grants are only issued from IDLE, so the pointer advances exactly once
  // per operation.
  assign w_launch = (state_q == ST_IDLE) && w_valid;

  mult_rr_arbiter u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .advance_i (w_launch),
    .winner_o  (w_win),
    .valid_o   (w_valid)
  );

  assign w_mcand  = w_win ? mcand_in[2*WIDTH-1:WIDTH]  : mcand_in[WIDTH-1:0];
  assign w_mplier = w_win ? mplier_in[2*WIDTH-1:WIDTH] : mplier_in[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      win_q      <= 1'b0;
      dt_q       <= 1'b0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mcand_t_q  <= 1'b0;
      mplier_t_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      done_t_q   <= 1'b0;
      start_q    <= 1'b0;
      start_t_q  <= 1'b0;
      result_q   <= '0;
      result_t_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      // Single-cycle strobes fall unless the transition below raises them.
      grant_q   <= '0;
      done_q    <= '0;
      done_t_q  <= 1'b0;
      start_q   <= 1'b0;
      start_t_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_valid) begin
            state_q    <= ST_LAUNCH;
            win_q      <= w_win;
            mcand_q    <= w_mcand;
            mplier_q   <= w_mplier;
            mcand_t_q  <= mcand_t[w_win];
            mplier_t_q <= mplier_t[w_win];
            dt_q       <= |req_t;
            grant_q    <= idx_to_onehot(w_win);
            start_q    <= 1'b1;
            start_t_q  <= |req_t;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          // A product arriving on the abort cycle still wins.
          if (mul_done) begin
            state_q    <= ST_DELIVER;
            result_q   <= mul_product;
            result_t_q <= mul_product_t | mul_done_t | dt_q;
            terr_q     <= 1'b0;
            done_q     <= idx_to_onehot(win_q);
            done_t_q   <= dt_q | mul_done_t;
          end else if (cnt_q == c_cnt_max) begin
            state_q    <= ST_DELIVER;
            result_q   <= '0;
            result_t_q <= dt_q | mul_done_t;
            terr_q     <= 1'b1;
            done_q     <= idx_to_onehot(win_q);
            done_t_q   <= dt_q | mul_done_t;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DELIVER: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant              = grant_q;
  assign done               = done_q;
  assign done_t             = done_t_q;
  assign result             = result_q;
  assign result_t           = result_t_q;
  assign timeout_err        = terr_q;
  assign mul_start          = start_q;
  assign mul_start_t        = start_t_q;
  assign mul_multiplicand   = mcand_q;
  assign mul_multiplier     = mplier_q;
  assign mul_multiplicand_t = mcand_t_q;
  assign mul_multiplier_t   = mplier_t_q;

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter_taint.md
MULT_SHARE_ARBITER_TAINT -- requirements
Module: mult_share_arbiter_taint

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width of the shared multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum number of WAIT cycles before the block aborts an operation.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 2: level request per requester i (bit i).
REQ-006 SHALL have port req_t, input, 2: taint of req[i].
REQ-007 SHALL have port mcand_in, input, 2*WIDTH: multiplicand of requester i in slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port mplier_in, input, 2*WIDTH: multiplier of requester i, sliced as for mcand_in.
REQ-009 SHALL have port mcand_t, input, 2: taint of requester i's multiplicand.
REQ-010 SHALL have port mplier_t, input, 2: taint of requester i's multiplier.
REQ-011 SHALL have port grant, output, 2: one-hot grant pulse.
REQ-012 SHALL have port done, output, 2: one-hot completion pulse.
REQ-013 SHALL have port done_t, output, 1: taint of done.
REQ-014 SHALL have port result, output, 2*WIDTH: product of the last operation.
REQ-015 SHALL have port result_t, output, 1: taint of result.
REQ-016 SHALL have port timeout_err, output, 1: the last operation aborted.
REQ-017 SHALL have ports mul_start, mul_start_t, output, 1 each: start to the multiplier, with taint.
REQ-018 SHALL have ports mul_multiplier, mul_multiplicand, output, WIDTH each, and mul_multiplier_t, mul_multiplicand_t, output, 1 each: operands to the multiplier, with taints.
REQ-019 SHALL have port mul_product, input, 2*WIDTH, and mul_product_t, input, 1: product from the multiplier, with taint.
REQ-020 SHALL have ports mul_done, mul_done_t, input, 1 each: productDone from the multiplier, with taint.

Function
REQ-021 SHALL implement states IDLE, LAUNCH, WAIT, DELIVER; IDLE->LAUNCH when |req; LAUNCH->WAIT unconditionally; WAIT->DELIVER on mul_done or on timeout; DELIVER->IDLE unconditionally.
REQ-022 SHALL pick the winner in IDLE: if only one req is set, that requester wins; if both are set, the round-robin pointer rr selects; rr moves to the non-winner on every grant.
REQ-023 SHALL, on the IDLE->LAUNCH edge, latch the winner index and its operands and operand taints, and latch decision taint dt = req_t[0] | req_t[1].
REQ-024 SHALL, in LAUNCH only, assert grant[winner] = 1 and mul_start = 1 for exactly one cycle, with mul_start_t = dt; operand outputs SHALL stay stable from LAUNCH through DELIVER.
REQ-025 SHALL ignore mul_done while in IDLE or LAUNCH, so a stale done is never accepted.
REQ-026 SHALL count WAIT cycles; on mul_done it SHALL capture result = mul_product, result_t = mul_product_t | mul_done_t | dt, and timeout_err = 0.
REQ-027 SHALL, at WAIT count = TIMEOUT without mul_done, capture result = 0, result_t = dt | mul_done_t, and timeout_err = 1; if mul_done and timeout coincide, mul_done wins.
REQ-028 SHALL, in DELIVER only, assert done[winner] = 1 for one cycle, with done_t = dt | mul_done_t.
REQ-029 SHALL hold result, result_t and timeout_err until the next capture.
REQ-030 SHALL leave a request that arrives while busy pending, with no grant, until the next IDLE; the requester keeps req high until grant.
REQ-031 SHALL give a minimum latency of WAIT-entry + mul latency + 1 cycle from req to done.
REQ-032 SHALL make the state sequence independent of operand values.

Reset
REQ-033 SHALL, while rst = 0, immediately force state IDLE and rr = 0, and set every output, latch, taint and counter to 0.
REQ-034 SHALL, on a reset mid-operation, produce no done pulse, and SHALL ignore a late mul_done that arrives in IDLE.

Structure
REQ-035 SHALL define the state encoding and the default TIMEOUT in a shared package, mult_arb_pkg.
REQ-036 SHALL place the two-way round-robin selection, including rr and its update, in a sub-module, mult_rr_arbiter.

Verification
REQ-037 SHALL cover, with WIDTH = 8: req = 01, operands 3x5, model done after 10 cycles -> grant[0] in LAUNCH, done[0] one cycle, result = 15, result_t = 0, timeout_err = 0.
REQ-038 SHALL cover: req = 11 held continuously after reset -> grant order 0, 1, 0, 1, with a single grant per operation.
REQ-039 SHALL cover: req = 01 with req_t = 10 -> mul_start_t = 1, done_t = 1, result_t = 1.
REQ-040 SHALL cover: mplier_t[1] = 1 and req = 10 with untainted model -> mul_multiplier_t = 1, result_t reflects mul_product_t only.
REQ-041 SHALL cover: model never asserts mul_done, TIMEOUT = 16 -> done pulse 17 cycles after WAIT entry, result = 0, timeout_err = 1.
REQ-042 SHALL cover: rst low for 1 cycle during WAIT, then late mul_done -> all outputs 0 and no done pulse.
